// File: rtl/rv32i_load_store_unit_if.sv
// Shared memory-port bundle between the load/store unit and the Von Neumann memory.
//   mem_req   : request valid, held until mem_ready completes it
//   mem_we    : 1 = write cycle
//   mem_addr  : word-aligned byte address
//   mem_wdata : lane-replicated store data
//   mem_wmask : byte enables (0000 on reads)
//   mem_rdata : read word, valid with mem_ready
//   mem_ready : completion of the current request
// master = load/store unit, slave = memory.
interface rv32i_load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/rv32i_load_store_unit.sv
// RV32I memory-access stage. Takes the ALU result as effective address, runs one
// load or store over the shared memory port, returns extended load data.
//   clk, reset         : clock, synchronous active-high reset
//   start_i            : request strobe, accepted only when idle
//   is_store_i         : 1 = SB/SH/SW, 0 = load
//   funct3_i           : RV32I width/sign code
//   addr_i             : effective byte address
//   store_data_i       : rs2 value
//   busy_o             : state != idle
//   done_o             : one-cycle completion pulse
//   load_data_o        : extended load result, valid with done_o
//   err_misaligned_o   : with done_o, misaligned address or illegal funct3
//   err_timeout_o      : with done_o, memory never answered
//   mem                : memory port (master side)
module rv32i_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TMO_W          = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_i,
  input  logic                           is_store_i,
  input  logic [2:0]                     funct3_i,
  input  logic [31:0]                    addr_i,
  input  logic [31:0]                    store_data_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [31:0]                    load_data_o,
  output logic                           err_misaligned_o,
  output logic                           err_timeout_o,
  rv32i_load_store_unit_if.master        mem
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e             state_q, state_d;
  logic [2:0]         funct3_q;
  logic [1:0]         off_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wmask_q;
  logic [TMO_W-1:0]   cnt_q;
  logic [31:0]        load_data_q;
  logic               err_mis_q;
  logic               err_tmo_q;

  logic               accept, complete, timeout, legal;
  logic [31:0]        fmt_wdata;
  logic [3:0]         fmt_wmask;
  logic [31:0]        rd_shift;
  logic [15:0]        rd_half;
  logic [31:0]        extracted;

  // Legality of the incoming request; stores only exist for B/H/W.
  always_comb begin
    legal = 1'b0;
    case (funct3_i)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr_i[0];
      3'b010:  legal = (addr_i[1:0] == 2'b00);
      3'b100:  legal = ~is_store_i;
      3'b101:  legal = ~is_store_i & ~addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  // Bus-side store formatting; reads present zero data and mask.
  always_comb begin
    fmt_wdata = '0;
    fmt_wmask = '0;
    if (is_store_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          fmt_wdata = {4{store_data_i[7:0]}};
          fmt_wmask = 4'b0001 << addr_i[1:0];
        end
        2'b01: begin
          fmt_wdata = {2{store_data_i[15:0]}};
          fmt_wmask = addr_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          fmt_wdata = store_data_i;
          fmt_wmask = 4'b1111;
        end
      endcase
    end
  end

  // Load extraction from the returned word using the latched byte offset.
  always_comb begin
    rd_shift  = mem.mem_rdata >> {off_q, 3'b000};
    rd_half   = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    extracted = mem.mem_rdata;
    case (funct3_q)
      3'b000:  extracted = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  extracted = {24'b0, rd_shift[7:0]};
      3'b001:  extracted = {{16{rd_half[15]}}, rd_half};
      3'b101:  extracted = {16'b0, rd_half};
      default: extracted = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          accept  = 1'b1;
          // Illegal requests skip the bus and report immediately.
          state_d = legal ? StReq : StResp;
        end
      end
      StReq: begin
        if (mem.mem_ready) begin
          complete = 1'b1;
          state_d  = StResp;
        end else if (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      funct3_q    <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
      err_mis_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q  <= funct3_i;
        off_q     <= addr_i[1:0];
        we_q      <= is_store_i;
        addr_q    <= {addr_i[31:2], 2'b00};
        wdata_q   <= fmt_wdata;
        wmask_q   <= fmt_wmask;
        cnt_q     <= '0;
        err_mis_q <= ~legal;
        err_tmo_q <= 1'b0;
      end
      if (state_q == StReq && !mem.mem_ready) cnt_q <= cnt_q + 1'b1;
      if (complete && !we_q) load_data_q <= extracted;
      if (timeout) begin
        load_data_q <= '0;
        err_tmo_q   <= 1'b1;
      end
    end
  end

  assign busy_o           = (state_q != StIdle);
  assign done_o           = (state_q == StResp);
  assign load_data_o      = load_data_q;
  assign err_misaligned_o = err_mis_q;
  assign err_timeout_o    = err_tmo_q;

  assign mem.mem_req   = (state_q == StReq);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wmask = wmask_q;

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Bench for rv32i_load_store_unit: a driver sequences transactions and publishes the
// per-cycle expected outputs from a behavioural model; a negedge process compares.
module tb_rv32i_load_store_unit;
  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i, is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic        busy_o, done_o, err_misaligned_o, err_timeout_o;
  logic [31:0] load_data_o;

  rv32i_load_store_unit_if bus ();

  rv32i_load_store_unit #(.TIMEOUT_CYCLES(TMO), .TMO_W(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .is_store_i       (is_store_i),
    .funct3_i         (funct3_i),
    .addr_i           (addr_i),
    .store_data_i     (store_data_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .load_data_o      (load_data_o),
    .err_misaligned_o (err_misaligned_o),
    .err_timeout_o    (err_timeout_o),
    .mem              (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  // Expected values for the current cycle.
  bit          exp_zero, exp_busy, exp_done, exp_req, exp_we, exp_emis, exp_etmo;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_wmask;
  logic [31:0] m_ld;  // model's held load result

  // Observations captured for literal checks.
  logic [31:0] obs_addr, obs_wdata, obs_ld;
  logic [3:0]  obs_wmask;
  logic        obs_we, obs_emis, obs_etmo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy_o), 32'(exp_busy));
      chk("done", 32'(done_o), 32'(exp_done));
      chk("mem_req", 32'(bus.mem_req), 32'(exp_req));
      if (exp_zero) begin
        chk("rst_load_data", load_data_o, 32'h0);
        chk("rst_err_mis", 32'(err_misaligned_o), 32'h0);
        chk("rst_err_tmo", 32'(err_timeout_o), 32'h0);
        chk("rst_we", 32'(bus.mem_we), 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_wmask", 32'(bus.mem_wmask), 32'h0);
      end
      if (exp_req) begin
        chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
        chk("mem_addr", bus.mem_addr, exp_addr);
        chk("mem_wdata", bus.mem_wdata, exp_wdata);
        chk("mem_wmask", 32'(bus.mem_wmask), 32'(exp_wmask));
      end
      if (exp_done) begin
        chk("load_data", load_data_o, exp_ld);
        chk("err_misaligned", 32'(err_misaligned_o), 32'(exp_emis));
        chk("err_timeout", 32'(err_timeout_o), 32'(exp_etmo));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_illegal(input bit st, input logic [2:0] f, input logic [31:0] a);
    bit ill = 0;
    if (!st && (f == 3 || f == 6 || f == 7)) ill = 1;
    if (st && f >= 3) ill = 1;
    if ((f == 1 || f == 5) && a[0]) ill = 1;
    if (f == 2 && (a % 4) != 0) ill = 1;
    return ill;
  endfunction

  function automatic logic [31:0] m_wdata(input bit st, input logic [2:0] f,
                                          input logic [31:0] sd);
    if (!st) return 32'h0;
    if (f == 0) return (sd & 32'hFF) * 32'h0101_0101;
    if (f == 1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [3:0] m_wmask(input bit st, input logic [2:0] f,
                                         input logic [31:0] a);
    int off = int'(a % 4);
    if (!st) return 4'h0;
    if (f == 0) return 4'(1 << off);
    if (f == 1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned off = a % 4;
    logic [31:0] byt = (rd >> (8 * off)) & 32'hFF;
    logic [31:0] hw  = (off >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
    case (f)
      3'b000:  return (byt >= 32'h80) ? (byt | 32'hFFFF_FF00) : byt;
      3'b100:  return byt;
      3'b001:  return (hw >= 32'h8000) ? (hw | 32'hFFFF_0000) : hw;
      3'b101:  return hw;
      default: return rd;
    endcase
  endfunction

  // Random values on inputs the DUT must ignore while busy.
  task automatic noise();
    start_i       = 1'($urandom_range(0, 1));
    is_store_i    = 1'($urandom_range(0, 1));
    funct3_i      = 3'($urandom_range(0, 7));
    addr_i        = $urandom;
    store_data_i  = $urandom;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
  endtask

  // Runs one transaction starting in an idle cycle; k = wait cycles before mem_ready,
  // negative means the memory never answers. Returns in the idle cycle after done.
  task automatic do_txn(input bit st, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int k);
    bit ill;
    bit tmo;
    int i;
    ill = m_illegal(st, f, a);
    start_i = 1'b1; is_store_i = st; funct3_i = f; addr_i = a; store_data_i = sd;
    bus.mem_ready = 1'($urandom_range(0, 1));  // ignored while idle
    bus.mem_rdata = $urandom;
    exp_zero = 0; exp_busy = 0; exp_done = 0; exp_req = 0;
    step();
    if (!ill) begin
      i = 0;
      tmo = 0;
      while (1) begin
        noise();
        exp_busy = 1; exp_done = 0; exp_req = 1; exp_we = st;
        exp_addr = a & 32'hFFFF_FFFC;
        exp_wdata = m_wdata(st, f, sd);
        exp_wmask = m_wmask(st, f, a);
        bus.mem_ready = (i == k);
        if (i == k) bus.mem_rdata = rd;
        if (i == 0) begin
          @(negedge clk);
          obs_addr = bus.mem_addr; obs_wdata = bus.mem_wdata;
          obs_wmask = bus.mem_wmask; obs_we = bus.mem_we;
        end
        step();
        if (i == k) break;
        if (i == int'(TMO) - 1) begin
          tmo = 1;
          break;
        end
        i++;
      end
      if (tmo) m_ld = 32'h0;
      else if (!st) m_ld = m_load(f, a, rd);
    end else begin
      tmo = 0;
    end
    // Completion cycle.
    noise();
    exp_req = 0; exp_busy = 1; exp_done = 1;
    exp_emis = ill; exp_etmo = tmo; exp_ld = m_ld;
    @(negedge clk);
    obs_ld = load_data_o; obs_emis = err_misaligned_o; obs_etmo = err_timeout_o;
    step();
    start_i = 1'b0;
    bus.mem_ready = 1'($urandom_range(0, 1));
    exp_busy = 0; exp_done = 0; exp_req = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit st;
    logic [2:0] f;
    logic [31:0] a;
    int k;
    int r;

    reset = 1'b1;
    start_i = 0; is_store_i = 0; funct3_i = 0; addr_i = 0; store_data_i = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    exp_zero = 1; exp_busy = 0; exp_done = 0; exp_req = 0; exp_we = 0;
    exp_emis = 0; exp_etmo = 0; exp_addr = 0; exp_wdata = 0; exp_wmask = 0; exp_ld = 0;
    m_ld = 0;
    step();
    chk_en = 1;
    step();
    reset = 1'b0;
    step();

    // Zero-wait LW.
    do_txn(0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    chk("lw_addr_lit", obs_addr, 32'h100);
    chk("lw_data_lit", obs_ld, 32'hDEAD_BEEF);
    chk("lw_err_lit", 32'({obs_emis, obs_etmo}), 32'h0);

    // Byte/half extraction.
    do_txn(0, 3'b000, 32'h203, 32'h0, 32'h8012_3456, 0);
    chk("lb_addr_lit", obs_addr, 32'h200);
    chk("lb_data_lit", obs_ld, 32'hFFFF_FF80);
    do_txn(0, 3'b100, 32'h203, 32'h0, 32'h8012_3456, 1);
    chk("lbu_data_lit", obs_ld, 32'h0000_0080);
    do_txn(0, 3'b001, 32'h202, 32'h0, 32'h8012_3456, 0);
    chk("lh_data_lit", obs_ld, 32'hFFFF_8012);

    // Store formatting; load_data must keep the last load value.
    do_txn(1, 3'b000, 32'h11, 32'h0000_00A5, 32'h0, 0);
    chk("sb_we_lit", 32'(obs_we), 32'h1);
    chk("sb_addr_lit", obs_addr, 32'h10);
    chk("sb_wmask_lit", 32'(obs_wmask), 32'h2);
    chk("sb_wdata_lit", obs_wdata, 32'hA5A5_A5A5);
    chk("sb_keep_ld_lit", obs_ld, 32'hFFFF_8012);
    do_txn(1, 3'b001, 32'h12, 32'h0000_1234, 32'h0, 2);
    chk("sh_wmask_lit", 32'(obs_wmask), 32'hC);
    chk("sh_wdata_lit", obs_wdata, 32'h1234_1234);

    // Illegal accesses.
    do_txn(0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    chk("lw_mis_lit", 32'(obs_emis), 32'h1);
    do_txn(1, 3'b001, 32'h101, 32'h5555, 32'h0, 0);
    chk("sh_mis_lit", 32'(obs_emis), 32'h1);
    do_txn(0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    chk("f3_011_lit", 32'(obs_emis), 32'h1);

    // Wait states, last-chance ready, timeout.
    do_txn(0, 3'b010, 32'h400, 32'h0, 32'h1357_9BDF, 3);
    chk("wait3_lit", obs_ld, 32'h1357_9BDF);
    do_txn(0, 3'b010, 32'h404, 32'h0, 32'h2468_ACE0, int'(TMO) - 1);
    chk("wait15_lit", obs_ld, 32'h2468_ACE0);
    do_txn(0, 3'b010, 32'h408, 32'h0, 32'h0, -1);
    chk("tmo_flag_lit", 32'(obs_etmo), 32'h1);
    chk("tmo_data_lit", obs_ld, 32'h0);

    // Reset in the middle of a request.
    start_i = 1; is_store_i = 0; funct3_i = 3'b010; addr_i = 32'h300; store_data_i = 0;
    bus.mem_ready = 0;
    exp_busy = 0; exp_done = 0; exp_req = 0;
    step();
    for (int c = 0; c < 4; c++) begin
      start_i = 0;
      bus.mem_ready = 0;
      exp_busy = 1; exp_req = 1; exp_we = 0; exp_addr = 32'h300; exp_wdata = 0; exp_wmask = 0;
      if (c == 3) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    m_ld = 0;
    exp_zero = 1; exp_busy = 0; exp_done = 0; exp_req = 0;
    step();
    do_txn(0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 1);
    chk("post_rst_lit", obs_ld, 32'hCAFE_F00D);

    // Randomized traffic.
    repeat (300) begin
      st = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 1) != 0) a[1] = 1'b0;
      r = int'($urandom_range(0, 19));
      k = int'($urandom_range(0, 4));
      if (r == 0) k = int'(TMO) - 1;
      if (r == 1 && !st) k = -1;
      do_txn(st, f, a, $urandom, $urandom, k);
    end

    step();
    step();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
